sump_cmd_seq: RTL and testbench

Command sequencer between the UART receiver and the instruction decoder. It assembles the incoming SUMP byte stream into complete commands: a 1-byte short command, or a 5-byte long command made of an opcode plus 32-bit data. For each complete command it issues exactly one strobe carrying the opcode, with the data word held alongside. An inter-byte timeout discards partial long commands so that a lost byte cannot desynchronise the stream.

---
 rtl/sump_cmd_seq.sv | 112 +++++++++++
 tb/tb_sump_cmd_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sump_cmd_seq.sv
// SUMP command sequencer: assembles short (1-byte) and long (opcode + 32-bit LE data) commands
// from the UART byte stream and emits one strobe per complete command.
module sump_cmd_seq #(
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic        rx_stb_i,
    input  logic [7:0]  rx_dat_i,
    output logic        stb_o,
    output logic [7:0]  opc_o,
    output logic [31:0] dat_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CntW-1:0] CntLast = (TIMEOUT_CYC > 0) ? CntW'(TIMEOUT_CYC - 1) : '0;
    localparam logic [CntW-1:0] CntMax  = '1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StData = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      opc_buf_q, opc_buf_d;
    logic [31:0]     dat_buf_q, dat_buf_d;
    logic [7:0]      opc_q, opc_d;
    logic [31:0]     dat_q, dat_d;
    logic            err_q, err_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        opc_buf_d = opc_buf_q;
        dat_buf_d = dat_buf_q;
        opc_d     = opc_q;
        dat_d     = dat_q;
        err_d     = 1'b0;

        case (state_q)
            // EMIT lasts one cycle but still accepts a byte, so back-to-back commands work.
            StIdle, StEmit: begin
                state_d = StIdle;
                if (rx_stb_i) begin
                    if (rx_dat_i[7]) begin
                        opc_buf_d = rx_dat_i;
                        idx_d     = 2'd0;
                        cnt_d     = '0;
                        state_d   = StData;
                    end else begin
                        opc_d   = rx_dat_i;
                        dat_d   = 32'h0;
                        state_d = StEmit;
                    end
                end
            end
            StData: begin
                if (rx_stb_i) begin
                    dat_buf_d[{idx_q, 3'b000} +: 8] = rx_dat_i;
                    idx_d = idx_q + 2'd1;
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        opc_d   = opc_buf_q;
                        dat_d   = {rx_dat_i, dat_buf_q[23:0]};
                        state_d = StEmit;
                    end
                end else if (TIMEOUT_CYC != 0) begin
                    if (cnt_q == CntLast) begin
                        state_d = StIdle;
                        err_d   = 1'b1;
                    end else if (cnt_q != CntMax) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            state_q   <= StIdle;
            idx_q     <= 2'd0;
            cnt_q     <= '0;
            opc_buf_q <= 8'h00;
            dat_buf_q <= 32'h0;
            opc_q     <= 8'h00;
            dat_q     <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            opc_buf_q <= opc_buf_d;
            dat_buf_q <= dat_buf_d;
            opc_q     <= opc_d;
            dat_q     <= dat_d;
            err_q     <= err_d;
        end
    end

    assign stb_o  = (state_q == StEmit);
    assign busy_o = (state_q == StData);
    assign opc_o  = opc_q;
    assign dat_o  = dat_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_sump_cmd_seq.sv
// Scoreboard bench for sump_cmd_seq: stimulus queues expected strobes/errors with due cycles,
// a negedge monitor pops and compares them.
module tb_sump_cmd_seq;

    logic        clk;
    logic        rst_n;
    logic        rx_stb;
    logic [7:0]  rx_dat;
    logic        stb;
    logic [7:0]  opc;
    logic [31:0] dat;
    logic        busy;
    logic        err;

    sump_cmd_seq #(.TIMEOUT_CYC(16)) dut (
        .clk_i    (clk),
        .rst_in   (rst_n),
        .rx_stb_i (rx_stb),
        .rx_dat_i (rx_dat),
        .stb_o    (stb),
        .opc_o    (opc),
        .dat_o    (dat),
        .busy_o   (busy),
        .err_o    (err)
    );

    typedef struct {
        logic [7:0]  opc;
        logic [31:0] dat;
        int          due;
    } exp_t;

    exp_t        sq[$];
    int          eq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [7:0]  last_opc = 8'h00;
    logic [31:0] last_dat = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: strobes and errors must match the scoreboard; outputs hold between strobes.
    always @(negedge clk) begin
        if (stb === 1'b1) begin
            if (sq.size() == 0) begin
                chk("unexpected_stb", {56'h0, opc}, 64'hFFFF);
            end else begin
                exp_t e;
                e = sq.pop_front();
                chk("stb_cycle", 64'(cyc), 64'(e.due));
                chk("stb_opc", {56'h0, opc}, {56'h0, e.opc});
                chk("stb_dat", {32'h0, dat}, {32'h0, e.dat});
                last_opc = e.opc;
                last_dat = e.dat;
            end
        end else begin
            chk("hold_opc", {56'h0, opc}, {56'h0, last_opc});
            chk("hold_dat", {32'h0, dat}, {32'h0, last_dat});
        end
        if (err === 1'b1) begin
            if (eq.size() == 0) chk("unexpected_err", 64'(cyc), 64'hFFFF_FFFF);
            else chk("err_cycle", 64'(cyc), 64'(eq.pop_front()));
        end
    end

    // Called at a negedge; byte is sampled at the next posedge, returns at the following negedge.
    task automatic send(input logic [7:0] b);
        rx_stb = 1'b1;
        rx_dat = b;
        @(negedge clk);
        rx_stb = 1'b0;
        rx_dat = 8'h00;
    endtask

    task automatic send_last(input logic [7:0] b, input logic [7:0] eo, input logic [31:0] ed);
        exp_t e;
        e.opc = eo;
        e.dat = ed;
        e.due = cyc + 1;
        sq.push_back(e);
        send(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n  = 1'b0;
        rx_stb = 1'b0;
        rx_dat = 8'h00;
        idle(3);
        chk("rst_stb", {63'h0, stb}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);
        chk("rst_opc", {56'h0, opc}, 64'h0);
        chk("rst_dat", {32'h0, dat}, 64'h0);
        rst_n = 1'b1;
        idle(2);

        // Short command
        send_last(8'h01, 8'h01, 32'h0);
        chk("short_busy", {63'h0, busy}, 64'h0);
        idle(3);

        // Long command with irregular gaps
        send(8'hC0);
        chk("long_busy0", {63'h0, busy}, 64'h1);
        send(8'h78);
        chk("long_busy1", {63'h0, busy}, 64'h1);
        idle(2);
        send(8'h56);
        idle(5);
        chk("long_busy2", {63'h0, busy}, 64'h1);
        send(8'h34);
        idle(3);
        chk("long_busy3", {63'h0, busy}, 64'h1);
        send_last(8'h12, 8'hC0, 32'h1234_5678);
        chk("long_busy_end", {63'h0, busy}, 64'h0);
        idle(3);

        // Timeout: err 17 edges after the 0xAA drive cycle, no strobe
        send(8'h80);
        eq.push_back(cyc + 17);
        send(8'hAA);
        idle(14);
        chk("to_busy_before", {63'h0, busy}, 64'h1);
        idle(6);
        chk("to_busy_after", {63'h0, busy}, 64'h0);
        send_last(8'h02, 8'h02, 32'h0);
        idle(3);

        // Byte arriving on the cycle the counter sits at TIMEOUT_CYC-1
        send(8'h80);
        send(8'h10);
        idle(15);
        send(8'h20);
        chk("edge_busy", {63'h0, busy}, 64'h1);
        send(8'h30);
        send_last(8'h40, 8'h80, 32'h4030_2010);
        idle(3);

        // Back-to-back short commands
        for (int i = 0; i < 5; i++) send_last(8'h00, 8'h00, 32'h0);
        send_last(8'h11, 8'h11, 32'h0);
        idle(3);

        // Reset mid-command
        send(8'h81);
        send(8'h01);
        send(8'h02);
        rst_n = 1'b0;
        @(posedge clk);
        last_opc = 8'h00;
        last_dat = 32'h0;
        @(negedge clk);
        chk("mrst_opc", {56'h0, opc}, 64'h0);
        chk("mrst_dat", {32'h0, dat}, 64'h0);
        chk("mrst_busy", {63'h0, busy}, 64'h0);
        chk("mrst_err", {63'h0, err}, 64'h0);
        rst_n = 1'b1;
        idle(2);
        send(8'h81);
        send(8'h04);
        send(8'h03);
        send(8'h02);
        send_last(8'h01, 8'h81, 32'h0102_0304);
        idle(20);

        chk("sq_drained", 64'(sq.size()), 64'h0);
        chk("eq_drained", 64'(eq.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
